// File: rtl/wb_mem_bist_if.sv
// Wishbone B3 classic bus between the BIST initiator and the memory slave.
interface wb_mem_bist_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;

  modport master (
    output cyc, stb, we, sel, adr, dat_w,
    input  dat_r, ack
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_w,
    output dat_r, ack
  );
endinterface

// File: rtl/wb_mem_bist.sv
// Memory BIST: writes a seeded, address-dependent pattern over 2^IDX_W words,
// reads it back, and reports pass/fail, error count, first failure and timeout.
module wb_mem_bist #(
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
  parameter int unsigned IDX_W     = 10,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 start_i,
  input  logic [31:0]          seed_i,
  wb_mem_bist_if.master        wbm,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 timeout_o,
  output logic [15:0]          err_count_o,
  output logic [31:0]          fail_addr_o,
  output logic [31:0]          fail_data_o
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned ERR_W = 16;
  localparam logic [IDX_W-1:0] IDX_LAST  = {IDX_W{1'b1}};
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WGAP  = 3'd2,
    READ  = 3'd3,
    RGAP  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        seed_q, seed_d;
  logic [CNT_W-1:0]   tmo_q, tmo_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [31:0]        faddr_q, faddr_d;
  logic [31:0]        fdata_q, fdata_d;

  logic               cyc_q, cyc_d;
  logic               stb_q, stb_d;
  logic               we_q, we_d;
  logic [3:0]         sel_q, sel_d;
  logic [31:0]        adr_q, adr_d;
  logic [31:0]        dat_q, dat_d;

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               tflag_q, tflag_d;
  logic [ERR_W-1:0]   err_out_q, err_out_d;
  logic [31:0]        faddr_out_q, faddr_out_d;
  logic [31:0]        fdata_out_q, fdata_out_d;

  logic               launch_c;
  logic               launch_we_c;
  logic [IDX_W-1:0]   launch_idx_c;
  logic               drop_c;
  logic               finish_c;

  // Test pattern: seed xor {~i, i} with i zero-extended to 16 bits.
  function automatic logic [31:0] pattern(input logic [31:0] seed, input logic [IDX_W-1:0] idx);
    logic [15:0] i16;
    i16 = 16'(idx);
    return seed ^ {~i16, i16};
  endfunction

  // Byte address of a word index; wraps mod 2^32.
  function automatic logic [31:0] word_addr(input logic [IDX_W-1:0] idx);
    return ADDR_BASE + (32'(idx) << 2);
  endfunction

  // Next-state, bus launch/drop and result bookkeeping.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    seed_d       = seed_q;
    tmo_d        = tmo_q;
    err_d        = err_q;
    faddr_d      = faddr_q;
    fdata_d      = fdata_q;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    we_d         = we_q;
    sel_d        = sel_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    tflag_d      = tflag_q;
    err_out_d    = err_out_q;
    faddr_out_d  = faddr_out_q;
    fdata_out_d  = fdata_out_q;
    launch_c     = 1'b0;
    launch_we_c  = 1'b0;
    launch_idx_c = idx_q;
    drop_c       = 1'b0;
    finish_c     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          seed_d       = seed_i;
          err_d        = '0;
          faddr_d      = '0;
          fdata_d      = '0;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          tflag_d      = 1'b0;
          err_out_d    = '0;
          faddr_out_d  = '0;
          fdata_out_d  = '0;
          busy_d       = 1'b1;
          launch_c     = 1'b1;
          launch_we_c  = 1'b1;
          launch_idx_c = '0;
          state_d      = WRITE;
        end
      end
      WRITE: begin
        if (wbm.ack) begin
          drop_c  = 1'b1;
          state_d = WGAP;
        end else if (tmo_q == TMO_LIMIT) begin
          tflag_d  = 1'b1;
          finish_c = 1'b1;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end
      WGAP: begin
        launch_c = 1'b1;
        if (idx_q == IDX_LAST) begin
          launch_we_c  = 1'b0;
          launch_idx_c = '0;
          state_d      = READ;
        end else begin
          launch_we_c  = 1'b1;
          launch_idx_c = idx_q + IDX_W'(1);
          state_d      = WRITE;
        end
      end
      READ: begin
        if (wbm.ack) begin
          drop_c  = 1'b1;
          state_d = RGAP;
          if (wbm.dat_r != pattern(seed_q, idx_q)) begin
            if (err_q == '0) begin
              faddr_d = adr_q;
              fdata_d = wbm.dat_r;
            end
            if (err_q != ERR_MAX) begin
              err_d = err_q + ERR_W'(1);
            end
          end
        end else if (tmo_q == TMO_LIMIT) begin
          tflag_d  = 1'b1;
          finish_c = 1'b1;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end
      RGAP: begin
        if (idx_q == IDX_LAST) begin
          finish_c = 1'b1;
        end else begin
          launch_c     = 1'b1;
          launch_we_c  = 1'b0;
          launch_idx_c = idx_q + IDX_W'(1);
          state_d      = READ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Results become visible together on the edge that enters DONE.
    if (finish_c) begin
      state_d     = DONE;
      drop_c      = 1'b1;
      busy_d      = 1'b0;
      done_d      = 1'b1;
      pass_d      = (err_d == '0) && !tflag_d;
      err_out_d   = err_d;
      faddr_out_d = faddr_d;
      fdata_out_d = fdata_d;
    end

    if (drop_c) begin
      cyc_d = 1'b0;
      stb_d = 1'b0;
      we_d  = 1'b0;
      sel_d = 4'h0;
    end

    if (launch_c) begin
      idx_d = launch_idx_c;
      cyc_d = 1'b1;
      stb_d = 1'b1;
      we_d  = launch_we_c;
      sel_d = 4'hF;
      adr_d = word_addr(launch_idx_c);
      dat_d = pattern(seed_d, launch_idx_c);
      tmo_d = '0;
    end
  end

  // State and registered outputs; reset abandons any test in flight.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      seed_q      <= '0;
      tmo_q       <= '0;
      err_q       <= '0;
      faddr_q     <= '0;
      fdata_q     <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 4'h0;
      adr_q       <= '0;
      dat_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      tflag_q     <= 1'b0;
      err_out_q   <= '0;
      faddr_out_q <= '0;
      fdata_out_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      seed_q      <= seed_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      faddr_q     <= faddr_d;
      fdata_q     <= fdata_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      tflag_q     <= tflag_d;
      err_out_q   <= err_out_d;
      faddr_out_q <= faddr_out_d;
      fdata_out_q <= fdata_out_d;
    end
  end

  assign wbm.cyc     = cyc_q;
  assign wbm.stb     = stb_q;
  assign wbm.we      = we_q;
  assign wbm.sel     = sel_q;
  assign wbm.adr     = adr_q;
  assign wbm.dat_w   = dat_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign timeout_o   = tflag_q;
  assign err_count_o = err_out_q;
  assign fail_addr_o = faddr_out_q;
  assign fail_data_o = fdata_out_q;

endmodule
